// File: rtl/seq_multiplier_8_bit.sv
// rtl/seq_multiplier_8_bit.sv - unsigned 8x8 shift-and-add multiplier sequencing one ripple adder
// The working register drops the spec's constant-zero carry bit: after every shift it is 0.

module full_adder_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
);

  logic [8:0] carry;

  assign carry[0] = c_in;

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_bit
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign c_out = carry[8];

endmodule

module seq_multiplier_8_bit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [7:0]  m_reg;
  logic [15:0] p_reg;

  logic [7:0]  add_b;
  logic [7:0]  sum;
  logic        c_out;
  logic [15:0] p_next;

  // Current multiplier bit selects whether the multiplicand is added into the high half.
  assign add_b = p_reg[0] ? m_reg : 8'h00;

  full_adder_8_bit u_adder (
    .a     (p_reg[15:8]),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // {c_out, sum, lo} shifted right by one; the adder carry lands in bit 15.
  assign p_next = {c_out, sum, p_reg[7:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      m_reg   <= 8'h00;
      p_reg   <= 16'h0000;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= a;
            p_reg <= {8'h00, b};
            cnt   <= 3'd0;
            state <= ST_RUN;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          p_reg <= p_next;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            product <= p_next;
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_8_bit.sv
// tb/tb_seq_multiplier_8_bit.sv - directed-vector bench for seq_multiplier_8_bit

module tb_seq_multiplier_8_bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int vectors = 0;
  int miscompares = 0;

  seq_multiplier_8_bit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done rises, bounded; flags any busy drop before done.
  task automatic wait_done(output int n, output bit busy_drop);
    n = 0;
    busy_drop = 0;
    while (!done && n < 20) begin
      if (!busy) busy_drop = 1;
      step();
      n++;
    end
  endtask

  task automatic accept(input logic [7:0] av, input logic [7:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_mul(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] exp);
    int n;
    bit drop;
    accept(av, bv);
    wait_done(n, drop);
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy_held"}, drop, 0);
    check({tag, "_product"}, product, exp);
    check({tag, "_busy_low"}, busy, 0);
    step();
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_product_hold"}, product, exp);
  endtask

  initial begin
    int n;
    bit drop;
    int seen;

    reset = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    step();
    step();
    reset = 1'b0;
    step();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 16'h0000);

    run_mul("m13x11", 8'd13, 8'd11, 16'h008F);
    run_mul("m255x255", 8'd255, 8'd255, 16'hFE01);
    run_mul("m80x02", 8'h80, 8'h02, 16'h0100);
    run_mul("m1x255", 8'd1, 8'd255, 16'h00FF);

    // back-to-back: second start held through the DONE cycle
    accept(8'd7, 8'd6);
    wait_done(n, drop);
    check("b2b1_latency", n, 8);
    check("b2b1_product", product, 16'd42);
    accept(8'd200, 8'd3);
    check("b2b_no_gap_busy", busy, 1);
    check("b2b_done_dropped", done, 0);
    check("b2b_product_held", product, 16'd42);
    wait_done(n, drop);
    check("b2b2_latency", n, 8);
    check("b2b2_busy_held", drop, 0);
    check("b2b2_product", product, 16'h0258);
    step();
    check("b2b2_done_one_cycle", done, 0);

    // start mid-RUN with other operands must be ignored
    accept(8'd5, 8'd9);
    step();
    a = 8'd3;
    b = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n, drop);
    check("midstart_latency", n + 2, 8);
    check("midstart_product", product, 16'd45);
    step();

    // reset during RUN cycle 4 abandons the operation
    accept(8'd9, 8'd9);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_product", product, 16'h0000);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen++;
      step();
    end
    check("midreset_no_done", seen, 0);
    run_mul("m0x99", 8'd0, 8'd99, 16'h0000);

    // reset and start on the same edge: reset wins
    a = 8'd4;
    b = 8'd4;
    start = 1'b1;
    reset = 1'b1;
    step();
    start = 1'b0;
    reset = 1'b0;
    check("reset_start_busy", busy, 0);
    step();
    check("reset_start_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_8_bit.md
Name: seq_multiplier_8_bit

Overview:
- Sequential shift-and-add controller for unsigned 8x8 multiplication, producing a 16-bit product.
- Sequences a single full_adder_8_bit instance, one partial product per clock. This reuses the existing ripple adder instead of an array multiplier.
- Sits between a simple start/done requester (lab top level, register file) and the adder datapath.

Parameters:
- None. Width is fixed at 8 to match full_adder_8_bit; the product is 16 bits.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiply; sampled on rising clk.
- a  input  8  multiplicand, captured when start is accepted.
- b  input  8  multiplier, captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result is valid.
- product  output  16  a*b, registered; holds the last result.

Behaviour:
- Internal state:
  - States: IDLE, RUN, DONE.
  - 3-bit counter cnt.
  - 8-bit multiplicand register M.
  - 17-bit working register P = {carry, hi[7:0], lo[7:0]}.
- Reset (reset=1 at rising clk, overrides everything):
  - state=IDLE, cnt=0, M=0, P=0.
  - busy=0, done=0, product=16'h0000.
- Start acceptance:
  - start is accepted only when state is IDLE or DONE.
  - On the accepting edge: M<=a, P<={9'b0, b}, cnt<=0, state<=RUN, busy<=1.
  - start in RUN is ignored; the a/b inputs are not re-sampled.
- Adder connection (purely combinational):
  - adder a = P[15:8].
  - adder b = P[0] ? M : 8'h00.
  - c_in = 0.
  - Output is sum[7:0] plus c_out.
- RUN step, each edge:
  - P <= {1'b0, c_out, sum[7:0], P[7:1]}, i.e. {c_out,sum} concatenated with lo, shifted right by one.
  - cnt <= cnt+1.
- RUN termination:
  - When cnt==7 at the edge, the step still executes.
  - Also on that edge: product <= final P[15:0], state<=DONE, busy<=0, done<=1.
- Latency:
  - Exactly 8 RUN edges.
  - done is high during the 9th cycle after the accepting edge (the cycle following the 9th edge counted from the accepting edge).
  - Throughput: one result per 9 cycles; back-to-back is allowed (see DONE).
- DONE:
  - Lasts exactly one cycle with done=1.
  - Next edge: if start=1, accept the new operation (DONE -> RUN, done<=0); else go to IDLE, done<=0.
- product register:
  - Updated only on the final RUN edge.
  - Does not show intermediate partial products.
  - Holds its value through IDLE and through subsequent RUN until the next completion.
- Arithmetic rules:
  - Unsigned only.
  - No overflow is possible: the max product is 255*255=65025=16'hFE01.
  - The carry bit of P is always 0 after the shift; c_out is absorbed into P[15].
- Reset mid-operation: the operation is abandoned with no done pulse, and product clears to 0.
- Reset together with start: reset wins; the state is IDLE after the edge.
- Zero operands: a=0 or b=0 still take the full 8 cycles; product=0.

Test Plan:
1. Reset held 2 cycles, then released -> busy=0, done=0, product=16'h0000.
2. a=13, b=11, start for 1 cycle -> busy high for 8 cycles; done pulses exactly 1 cycle at the 9th cycle after the accepting edge; product=143 (16'h008F).
3. a=255, b=255 -> product=16'hFE01. Also a=8'h80, b=8'h02 -> 16'h0100, which checks carry propagation into the upper byte.
4. Back-to-back: start with 7*6, then start held during the DONE cycle with 200*3 -> first product=42; second accepted with no IDLE gap, product=600 (16'h0258) 9 cycles later; done pulses twice, never merged.
5. Start pulsed again mid-RUN with different a/b -> ignored; result equals the original operands; cnt and timing unchanged.
6. Reset asserted at RUN cycle 4 -> next cycle is IDLE, busy=0, no done pulse, product=0. A new start then completes normally, e.g. 0*99 -> 0 after 9 cycles.
